bird_frame_controller: RTL and testbench
========================================

# bird_frame_controller

Upstream control stage for the pixel datapath. It runs the bird physics (flap impulse, gravity, clamping) once per frame and sequences every frame as erase-old, then draw-new, by pulsing the datapath's load strobe with the right `oldOrCurrent` value. It waits for `finishedPrintingSignal` after each pass and latches game-over when the datapath reports a collision or the bird reaches the ground. Its outputs drive the datapath's `xInput`/`yInput`/`loadDatapath`/`oldOrCurrent` inputs and the VGA adapter write enable.

## Interface
Parameters:
- `FRAME_TICKS`, default 833333: clk cycles per frame (60 Hz at 50 MHz); minimum 2.
- `BIRD_X`, default 78: fixed bird x coordinate.
- `Y_START`, default 58: bird y after reset.
- `Y_MAX`, default 116: lowest legal bird y, which is the ground row (120 − 4-px bird).
- `FLAP_VEL`, default 4: upward speed applied on a flap, 1..7.
- `GRAVITY`, default 1: per-frame velocity increment.
- `MAX_FALL`, default 3: terminal downward velocity, 1..7.

Ports:
- `clk` in 1: single clock.
- `resetLow` in 1: asynchronous, active-low reset.
- `flap` in 1: player button, active-high, already synchronous and debounced.
- `finishedPrintingSignal` in 1: datapath pass complete.
- `collisionHappened` in 1: datapath collision flag, level.
- `xBird` out 8: bird x to datapath.
- `yBird` out 7: bird y to datapath.
- `loadDatapath` out 1: one-cycle load strobe.
- `oldOrCurrent` out 1: 0 = erase pass, 1 = draw pass (also advances pipes).
- `plotEnable` out 1: VGA write enable.
- `gameOver` out 1: sticky end-of-game flag.

## Operation
- State machine: IDLE → LOAD_ERASE → ERASE → UPDATE → LOAD_DRAW → DRAW → WAIT_FRAME → LOAD_ERASE …; a GAME_OVER state is terminal.
- **IDLE**: all strobes low. A rising edge of `flap` moves to LOAD_ERASE. That edge also sets `flapPending`.
- **LOAD_ERASE**: `loadDatapath`=1 and `oldOrCurrent`=0 for one cycle. `xBird`/`yBird` hold the previous position.
- **ERASE**: `plotEnable`=1. The state ignores `finishedPrintingSignal` in its first cycle, then waits for it to be 1 and moves to UPDATE.
- **UPDATE** (one cycle): computes the new velocity `vel`, then the new y, then checks for game over. `vel` is signed 5-bit, positive = down.
  - New velocity: if `flapPending`, vel ← −FLAP_VEL and `flapPending` clears. Otherwise vel ← min(vel+GRAVITY, MAX_FALL).
  - New y: y ← clamp(y + new vel, 0, Y_MAX). Compute in signed 9-bit; a negative result clamps to 0 (ceiling, not fatal).
  - Game over: if the new y = Y_MAX, or `collisionHappened`=1, go to GAME_OVER. Otherwise go to LOAD_DRAW.
- **LOAD_DRAW**: `loadDatapath`=1 and `oldOrCurrent`=1 for one cycle, with the new `yBird`.
- **DRAW**: same wait rule as ERASE, then moves to WAIT_FRAME. If `collisionHappened`=1 on exit, go to GAME_OVER instead.
- **WAIT_FRAME**: waits for `framePending`, clears it, then moves to LOAD_ERASE.
- **GAME_OVER**: `gameOver`=1, all strobes 0, bird frozen. Only reset leaves this state.
- **Frame counter**: runs freely from reset, 0..FRAME_TICKS−1, and sets `framePending` on wrap. `framePending` is a single bit, so overrun frames are dropped, never queued. If the wrap and the clear happen in the same cycle, the set wins.
- **Flap edge detect**: a registered previous `flap` value detects rising edges. An edge sets `flapPending` in any state except GAME_OVER. A set and a clear in the same UPDATE cycle leaves it set. Holding `flap` high produces exactly one flap.

## Timing
- Reset (asynchronous): state=IDLE, `xBird`=BIRD_X, `yBird`=Y_START, vel=0, all flags and counters 0, and every 1-bit output 0.
- All outputs are registered. `loadDatapath` is high for exactly one cycle per pass.
- `oldOrCurrent` and `yBird` are valid in the load cycle and stay stable until the next load.
- Flap to first movement: the edge is registered 1 cycle later and consumed in the next UPDATE.
- An edge arriving after UPDATE is applied in the following frame.
- Minimum frame length: 4 + erase pass + draw pass cycles. If FRAME_TICKS is shorter, frame rate equals print rate.
- Reset asserted mid-pass aborts immediately. Strobes drop asynchronously.

## Test plan
- **Reset and start.** Hold reset, release, leave `flap`=0 for 100 cycles → IDLE; `loadDatapath` never pulses; `yBird`=58, `xBird`=78.
- **Flap and gravity.** Use FRAME_TICKS=64 and a model that returns `finishedPrintingSignal` 10 cycles after each load. Pulse `flap` once → per-frame `yBird` is 54, 51, 49, 48, 48, 49, 51, 54, 57, 60 (terminal 3/frame). Every erase load has `oldOrCurrent`=0 and precedes a draw load with 1.
- **Ceiling.** Start at `yBird`=2 and flap → `yBird`=0, vel=−4. Play continues with no `gameOver`.
- **Ground.** Never flap after start → `yBird` climbs by +3 per frame to 116 → `gameOver`=1 in that UPDATE. No further loads; `yBird` stays frozen at 116.
- **Collision.** Raise `collisionHappened` during a DRAW pass → GAME_OVER at DRAW exit; `plotEnable` and `loadDatapath` stay 0.
- **Edge cases.**
  - Hold `flap` high for 5 frames → exactly one impulse.
  - Delay `finishedPrintingSignal` by 200 cycles with FRAME_TICKS=64 → one load pair per print completion, no back-to-back loads.
  - Assert reset mid-ERASE → outputs return to reset values within the reset cycle.

Source files
------------

// File: rtl/bird_frame_controller.sv
// Per-frame bird physics and erase/draw pass sequencing for the pixel datapath.
// Game over latches on a collision or when the bird reaches the ground row.
module bird_frame_controller #(
  parameter int FRAME_TICKS = 833333,
  parameter int BIRD_X      = 78,
  parameter int Y_START     = 58,
  parameter int Y_MAX       = 116,
  parameter int FLAP_VEL    = 4,
  parameter int GRAVITY     = 1,
  parameter int MAX_FALL    = 3
) (
  input  logic       clk,
  input  logic       resetLow,
  input  logic       flap,
  input  logic       finishedPrintingSignal,
  input  logic       collisionHappened,
  output logic [7:0] xBird,
  output logic [6:0] yBird,
  output logic       loadDatapath,
  output logic       oldOrCurrent,
  output logic       plotEnable,
  output logic       gameOver
);

  localparam int CW = $clog2(FRAME_TICKS);

  typedef enum logic [2:0] {
    IDLE, LOAD_ERASE, ERASE, UPDATE, LOAD_DRAW, DRAW, WAIT_FRAME, GAME_OVER
  } stateT;

  stateT             state;
  logic [CW-1:0]     frameCount;
  logic              frameWrap;
  logic              framePending;
  logic              flapPrev;
  logic              flapPending;
  logic              flapEdge;
  logic              passFirst;
  logic signed [4:0] vel;
  logic signed [5:0] velGrav;
  logic signed [4:0] velNext;
  logic signed [8:0] ySum;
  logic [6:0]        yNext;

  assign frameWrap = (frameCount == CW'(FRAME_TICKS - 1));
  assign flapEdge  = flap & ~flapPrev;

  always_ff @(posedge clk or negedge resetLow) begin
    if (!resetLow) begin
      frameCount <= '0;
    end else if (frameWrap) begin
      frameCount <= '0;
    end else begin
      frameCount <= frameCount + 1'b1;
    end
  end

  // Velocity first, then position from the new velocity, clamped to the playfield.
  always_comb begin
    velGrav = 6'(vel) + 6'(GRAVITY);
    velNext = '0;
    yNext   = '0;
    if (flapPending) begin
      velNext = 5'(-FLAP_VEL);
    end else if (velGrav > 6'(MAX_FALL)) begin
      velNext = 5'(MAX_FALL);
    end else begin
      velNext = velGrav[4:0];
    end
    ySum = $signed({2'b00, yBird}) + 9'(velNext);
    if (ySum < 9'sd0) begin
      yNext = '0;
    end else if (ySum >= 9'(Y_MAX)) begin
      yNext = 7'(Y_MAX);
    end else begin
      yNext = ySum[6:0];
    end
  end

  always_ff @(posedge clk or negedge resetLow) begin
    if (!resetLow) begin
      state        <= IDLE;
      xBird        <= 8'(BIRD_X);
      yBird        <= 7'(Y_START);
      vel          <= '0;
      framePending <= 1'b0;
      flapPrev     <= 1'b0;
      flapPending  <= 1'b0;
      passFirst    <= 1'b0;
      loadDatapath <= 1'b0;
      oldOrCurrent <= 1'b0;
      plotEnable   <= 1'b0;
      gameOver     <= 1'b0;
    end else begin
      flapPrev     <= flap;
      loadDatapath <= 1'b0;
      case (state)
        IDLE: begin
          if (flapEdge) begin
            state        <= LOAD_ERASE;
            loadDatapath <= 1'b1;
            oldOrCurrent <= 1'b0;
          end
        end
        LOAD_ERASE: begin
          state      <= ERASE;
          plotEnable <= 1'b1;
          passFirst  <= 1'b1;
        end
        ERASE: begin
          passFirst <= 1'b0;
          if (!passFirst && finishedPrintingSignal) begin
            plotEnable <= 1'b0;
            state      <= UPDATE;
          end
        end
        UPDATE: begin
          vel         <= velNext;
          yBird       <= yNext;
          flapPending <= 1'b0;
          if (yNext == 7'(Y_MAX) || collisionHappened) begin
            state    <= GAME_OVER;
            gameOver <= 1'b1;
          end else begin
            state        <= LOAD_DRAW;
            loadDatapath <= 1'b1;
            oldOrCurrent <= 1'b1;
          end
        end
        LOAD_DRAW: begin
          state      <= DRAW;
          plotEnable <= 1'b1;
          passFirst  <= 1'b1;
        end
        DRAW: begin
          passFirst <= 1'b0;
          if (!passFirst && finishedPrintingSignal) begin
            plotEnable <= 1'b0;
            if (collisionHappened) begin
              state    <= GAME_OVER;
              gameOver <= 1'b1;
            end else begin
              state <= WAIT_FRAME;
            end
          end
        end
        WAIT_FRAME: begin
          if (framePending) begin
            framePending <= 1'b0;
            state        <= LOAD_ERASE;
            loadDatapath <= 1'b1;
            oldOrCurrent <= 1'b0;
          end
        end
        GAME_OVER: begin
          gameOver   <= 1'b1;
          plotEnable <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      // Placed after the case so a set in the same cycle overrides any clear above.
      if (frameWrap) framePending <= 1'b1;
      if (flapEdge && state != GAME_OVER) flapPending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bird_frame_controller.sv
// Self-checking bench for bird_frame_controller: a print-completion responder,
// randomized flaps/print delays, and a frame-level physics reference model.
module tb_bird_frame_controller;

  localparam int FT     = 64;
  localparam int YMAX   = 116;
  localparam int YSTART = 58;
  localparam int BX     = 78;

  logic       clk = 1'b0;
  logic       resetLow;
  logic       flap;
  logic       finishedPrintingSignal;
  logic       collisionHappened;
  logic [7:0] xBird;
  logic [6:0] yBird;
  logic       loadDatapath;
  logic       oldOrCurrent;
  logic       plotEnable;
  logic       gameOver;

  always #5 clk = ~clk;

  bird_frame_controller #(.FRAME_TICKS(FT)) dut (
    .clk                    (clk),
    .resetLow               (resetLow),
    .flap                   (flap),
    .finishedPrintingSignal (finishedPrintingSignal),
    .collisionHappened      (collisionHappened),
    .xBird                  (xBird),
    .yBird                  (yBird),
    .loadDatapath           (loadDatapath),
    .oldOrCurrent           (oldOrCurrent),
    .plotEnable             (plotEnable),
    .gameOver               (gameOver)
  );

  int     nCompared   = 0;
  int     nMismatched = 0;
  longint cyc         = 0;
  int     loadCount   = 0;
  int     printDelay  = 10;
  int     modelY;
  int     modelVel;
  bit     modelFlap;
  bit     holdFlap    = 1'b0;
  logic   prevLoad    = 1'b0;

  int gravTab [10] = '{54, 51, 49, 48, 48, 49, 51, 54, 57, 60};

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Every load must be a single-cycle pulse.
  initial forever begin
    @(negedge clk);
    if (loadDatapath === 1'b1) begin
      loadCount++;
      checkVal("loadWidth", 32'(prevLoad), 0);
    end
    prevLoad = loadDatapath;
  end

  // Datapath stand-in: finish a pass printDelay cycles after each load.
  initial forever begin
    int d;
    @(negedge clk);
    if (loadDatapath === 1'b1 && resetLow === 1'b1) begin
      d = printDelay;
      repeat (d) @(negedge clk);
      finishedPrintingSignal = 1'b1;
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk);
        if (plotEnable !== 1'b1) break;
      end
      finishedPrintingSignal = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic void modelStep();
    if (modelFlap) modelVel = -4;
    else           modelVel = (modelVel + 1 > 3) ? 3 : modelVel + 1;
    modelFlap = 1'b0;
    modelY = modelY + modelVel;
    if (modelY < 0)    modelY = 0;
    if (modelY > YMAX) modelY = YMAX;
  endfunction

  task automatic waitLoad(output logic ooc, output logic [6:0] y, output longint at, output bit ok);
    ok = 1'b0; ooc = 1'bx; y = 'x; at = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (loadDatapath === 1'b1) begin
        ooc = oldOrCurrent; y = yBird; at = cyc; ok = 1'b1;
        break;
      end
    end
    if (!ok) checkVal("loadTimeout", 0, 1);
  endtask

  task automatic waitGameOver();
    int n;
    bit seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (gameOver === 1'b1) begin seen = 1'b1; break; end
    end
    checkVal("gameOverSet", 32'(seen), 1);
    checkVal("frozenY", 32'(yBird), modelY);
    n = loadCount;
    repeat (300) @(negedge clk);
    checkVal("noLoadsAfterEnd", loadCount - n, 0);
    checkVal("plotAfterEnd", 32'(plotEnable), 0);
    checkVal("gameOverSticky", 32'(gameOver), 1);
    checkVal("frozenYLater", 32'(yBird), modelY);
  endtask

  task automatic playFrame(input bit flapNext, output bit ended, output int drawY);
    logic       ooc;
    logic [6:0] y;
    longint     tE, tD;
    bit         ok;
    ended = 1'b0; drawY = -1;
    waitLoad(ooc, y, tE, ok);
    if (!ok) begin ended = 1'b1; return; end
    if (!holdFlap) flap = 1'b0;
    checkVal("eraseOoc", 32'(ooc), 0);
    checkVal("eraseY", 32'(y), modelY);
    modelStep();
    if (modelY == YMAX) begin
      waitGameOver();
      ended = 1'b1;
      return;
    end
    waitLoad(ooc, y, tD, ok);
    if (!ok) begin ended = 1'b1; return; end
    checkVal("drawOoc", 32'(ooc), 1);
    checkVal("drawY", 32'(y), modelY);
    checkVal("passGap", 32'(int'(tD - tE)), ((printDelay < 2) ? 2 : printDelay) + 2);
    checkVal("gameOverLow", 32'(gameOver), 0);
    drawY = int'(y);
    if (flapNext) begin
      flap = 1'b1;
      modelFlap = 1'b1;
    end
  endtask

  task automatic startGame();
    modelY = YSTART; modelVel = 0; modelFlap = 1'b1;
    flap = 1'b1;
  endtask

  task automatic resetDut();
    int n;
    resetLow = 1'b0; flap = 1'b0; collisionHappened = 1'b0; holdFlap = 1'b0;
    printDelay = 10;
    repeat (3) @(negedge clk);
    checkVal("rstX", 32'(xBird), BX);
    checkVal("rstY", 32'(yBird), YSTART);
    checkVal("rstLoad", 32'(loadDatapath), 0);
    checkVal("rstOoc", 32'(oldOrCurrent), 0);
    checkVal("rstPlot", 32'(plotEnable), 0);
    checkVal("rstGameOver", 32'(gameOver), 0);
    n = loadCount;
    resetLow = 1'b1;
    repeat (300) @(negedge clk);
    checkVal("idleNoLoads", loadCount - n, 0);
    checkVal("idleY", 32'(yBird), YSTART);
    checkVal("idlePlot", 32'(plotEnable), 0);
  endtask

  initial begin
    bit         ended;
    int         dy;
    logic       ooc;
    logic [6:0] y;
    longint     t;
    bit         ok;

    resetLow = 1'b0; flap = 1'b0; finishedPrintingSignal = 1'b0; collisionHappened = 1'b0;
    resetDut();

    // One flap, then free fall all the way to the ground.
    startGame();
    ended = 1'b0;
    for (int f = 0; f < 60 && !ended; f++) begin
      playFrame(1'b0, ended, dy);
      if (f < 10 && !ended) checkVal("gravSeq", dy, gravTab[f]);
    end

    // Flap every frame into the ceiling, then random play.
    resetDut();
    startGame();
    ended = 1'b0;
    for (int f = 0; f < 20 && !ended; f++) begin
      playFrame(1'b1, ended, dy);
      if (!ended) checkVal("ceilingSeq", dy, (54 - 4 * f < 0) ? 0 : 54 - 4 * f);
    end
    checkVal("ceilingNoGameOver", 32'(gameOver), 0);
    for (int f = 0; f < 40 && !ended; f++) begin
      printDelay = $urandom_range(1, 20);
      playFrame($urandom_range(0, 2) == 0, ended, dy);
    end

    // Holding flap high across frames yields a single impulse.
    resetDut();
    holdFlap = 1'b1;
    startGame();
    for (int f = 0; f < 5; f++) begin
      playFrame(1'b0, ended, dy);
      checkVal("holdSeq", dy, gravTab[f]);
    end
    holdFlap = 1'b0;
    flap = 1'b0;
    playFrame(1'b0, ended, dy);
    checkVal("holdSeqAfter", dy, gravTab[5]);

    // Prints much slower than the frame tick.
    resetDut();
    printDelay = 200;
    startGame();
    for (int f = 0; f < 4; f++) begin
      playFrame(1'b0, ended, dy);
      checkVal("slowSeq", dy, gravTab[f]);
    end
    printDelay = 10;

    // Collision raised during a draw pass.
    resetDut();
    startGame();
    playFrame(1'b0, ended, dy);
    playFrame(1'b0, ended, dy);
    collisionHappened = 1'b1;
    waitGameOver();
    collisionHappened = 1'b0;

    // Reset in the middle of an erase pass.
    resetDut();
    startGame();
    playFrame(1'b0, ended, dy);
    playFrame(1'b0, ended, dy);
    waitLoad(ooc, y, t, ok);
    checkVal("midEraseOoc", 32'(ooc), 0);
    @(negedge clk);
    checkVal("midErasePlot", 32'(plotEnable), 1);
    #2 resetLow = 1'b0;
    #1;
    checkVal("abortPlot", 32'(plotEnable), 0);
    checkVal("abortLoad", 32'(loadDatapath), 0);
    checkVal("abortY", 32'(yBird), YSTART);
    checkVal("abortX", 32'(xBird), BX);
    checkVal("abortGameOver", 32'(gameOver), 0);
    resetDut();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
